muller_c_handshake_driver: RTL
==============================

# muller_c_handshake_driver

Clocked four-phase stimulus generator and checker for the Muller C-element under test. Drives the element's two inputs `a_out` and `b_out` through complete return-to-zero handshakes with a programmable skew between them. It synchronises the element's asynchronous output `c_in` back into the clock domain and checks the C-element hold property during every skew window. It also counts completed handshakes and flags timeouts, so the element can be exercised on silicon from the user I/O pins.

## Interface
- `SYNC_STAGES`, 2: flops in the `c_in` synchroniser (≥2).
- `TIMEOUT_CYCLES`, 255: clocks allowed for `c` to reach the expected level.
- `CNT_W`, 16: width of `cycle_count`.

- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  pulse; begins a run from IDLE.
- `stop`  in  1  pulse; ends a continuous run after the current handshake.
- `clr`  in  1  pulse; leaves ERROR.
- `n_cycles`  in  8  handshakes per run, sampled on `start`; 0 = continuous.
- `skew`  in  4  clocks between `a_out` and `b_out` edges, sampled on `start`.
- `c_in`  in  1  C-element output, asynchronous.
- `a_out`, `b_out`  out  1 each  C-element inputs, registered.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse when a run ends normally.
- `timeout`  out  1  sticky; cleared by `clr` or `start`.
- `hold_err`  out  1  sticky; cleared by `clr` or `start`.
- `cycle_count`  out  `CNT_W`  completed handshakes, saturating.

## Operation
- `c_sync` is `c_in` after `SYNC_STAGES` flops. All decisions use `c_sync` only.
- States:
  - IDLE
  - RISE_SKEW: `a_out`=1, `b_out`=0
  - WAIT_HI: both high
  - FALL_SKEW: `a_out`=0, `b_out`=1
  - WAIT_LO: both low
  - DONE
  - ERROR
- **IDLE.** On `start`:
  - latch `n_cycles` and `skew`;
  - clear `cycle_count`, `timeout` and `hold_err`;
  - go to RISE_SKEW with `a_out`=1.
- **RISE_SKEW.** Skew counter loads `skew` on entry.
  - On expiry, `b_out`=1 and the state goes to WAIT_HI.
  - With `skew`=0, `a_out` and `b_out` rise in the same cycle and RISE_SKEW lasts zero cycles.
  - `c_sync`=1 while in RISE_SKEW: set `hold_err`, go to ERROR.
- **WAIT_HI.** `c_sync`=1: go to FALL_SKEW with `a_out`=0.
- **FALL_SKEW.** Mirror of RISE_SKEW.
  - `c_sync`=0 while in FALL_SKEW: set `hold_err`, go to ERROR.
  - On expiry, `b_out`=0 and the state goes to WAIT_LO.
- **WAIT_LO.** `c_sync`=0 completes a handshake and `cycle_count` increments, saturating at all-ones. Then:
  - `n_cycles`≠0 and the new count equals `n_cycles`: go to DONE;
  - else if a stop request is latched: go to DONE;
  - else go to RISE_SKEW.
- **Timeout.** The timeout counter resets on entry to WAIT_HI or WAIT_LO. Reaching `TIMEOUT_CYCLES` there sets `timeout` and goes to ERROR.
- **DONE.** `done`=1 for one cycle, then IDLE.
- **ERROR.** `a_out`=`b_out`=0. Stays until `clr`, then goes to IDLE; the sticky flags keep their values.
- **Stop requests.** A `stop` pulse in any busy state is latched and acted on at the next handshake completion. A `stop` pulse in IDLE is ignored.
- **Ignored inputs.** `start` while busy is ignored. `clr` outside ERROR is ignored.
- Hold detection is only guaranteed for premature `c` edges occurring more than `SYNC_STAGES` clocks before the skew window closes.

## Timing
- **Reset.** All outputs are 0 immediately on `rst_n` low. State is IDLE and all counters and synchroniser flops are 0. Reset mid-handshake drops `a_out`/`b_out` asynchronously.
- **Start latency.** `start` high at edge T gives `a_out`=1 after T and `b_out`=1 after T+`skew`.
- **Return to low.** `c_in` rising before edge U is seen as `c_sync`=1 after U+`SYNC_STAGES`-1. `a_out` falls at the following edge.
- **Outputs.** All outputs are registered. `done` lasts exactly one cycle.
- **Simultaneous events.** Completion of the last counted handshake and `stop` in the same cycle produce a single `done`. Timeout and `hold_err` in the same cycle cannot occur, because they are checked in different states.

## Test plan
- **Normal counted run.** Model C-element with 3-clock delay; `n_cycles`=4, `skew`=2, `start` → 4 handshakes, `b_out` rising 2 clocks after `a_out` each time, `cycle_count`=4, one `done` pulse, `busy` back to 0.
- **Premature output.** Output follows `a_out` alone (broken element); `skew`=6 → `hold_err`=1, ERROR, `a_out`=`b_out`=0. `clr` → IDLE with `hold_err` still 1. Next `start` clears it.
- **Stuck output.** `c_in` tied 0 → `timeout`=1 exactly 255 clocks after WAIT_HI entry; `cycle_count`=0.
- **Continuous run with stop.** `n_cycles`=0; `stop` pulsed mid-handshake 10 → exactly 10 completed, `done` once, ignoring a `start` pulsed while busy.
- **Reset mid-operation.** `rst_n` low during WAIT_HI → `a_out`, `b_out` and `busy` go 0 without a clock edge; after release, IDLE and `cycle_count`=0.
- **Zero skew.** `skew`=0 → `a_out` and `b_out` toggle on the same edge; no `hold_err`.

Source files
------------

// File: rtl/muller_c_handshake_driver_if.sv
// Handshake/control bundle for the Muller C-element handshake driver.
//   start, stop, clr     : one-cycle control pulses into the driver
//   n_cycles, skew       : run configuration, sampled on start
//   c_in                 : asynchronous output of the C-element under test
//   a_out, b_out         : registered C-element inputs driven by the driver
//   busy, done           : run status (done is a one-cycle pulse)
//   timeout, hold_err    : sticky failure flags
//   cycle_count          : completed handshakes, saturating
// Modport master is the driver; modport slave is the environment around it.
interface muller_c_handshake_driver_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             stop;
  logic             clr;
  logic [7:0]       n_cycles;
  logic [3:0]       skew;
  logic             c_in;
  logic             a_out;
  logic             b_out;
  logic             busy;
  logic             done;
  logic             timeout;
  logic             hold_err;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    input  start, stop, clr, n_cycles, skew, c_in,
    output a_out, b_out, busy, done, timeout, hold_err, cycle_count
  );

  modport slave (
    output start, stop, clr, n_cycles, skew, c_in,
    input  a_out, b_out, busy, done, timeout, hold_err, cycle_count
  );
endinterface

// File: rtl/muller_c_handshake_driver.sv
// Four-phase stimulus generator and checker for a Muller C-element.
// Drives a_out/b_out through return-to-zero handshakes with a programmable
// skew, synchronises the element output c_in, flags a premature output
// change inside a skew window (hold_err) or a missing one (timeout), and
// counts completed handshakes.
// Ports:
//   clk   : single clock
//   rst_n : asynchronous active-low reset
//   bus   : master modport of muller_c_handshake_driver_if (see that file)
module muller_c_handshake_driver #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  muller_c_handshake_driver_if.master bus
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RISE_SKEW,
    S_WAIT_HI,
    S_FALL_SKEW,
    S_WAIT_LO,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            r_state, w_state_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic              w_c_sync;

  logic              r_a, w_a_next;
  logic              r_b, w_b_next;
  logic              r_busy;
  logic              r_done, w_done_next;
  logic              r_timeout, w_timeout_next;
  logic              r_hold_err, w_hold_err_next;
  logic              r_stop_req, w_stop_req_next;
  logic [CNT_W-1:0]  r_count, w_count_next, w_count_inc;
  logic [7:0]        r_n, w_n_next;
  logic [3:0]        r_skew, w_skew_next;
  logic [3:0]        r_skew_cnt, w_skew_cnt_next;
  logic [TO_W-1:0]   r_to_cnt, w_to_cnt_next;
  logic              w_launch;
  logic [3:0]        w_launch_skew;

  // c_in enters at bit 0; decisions use only the last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], bus.c_in};
  end
  assign w_c_sync = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_a        <= 1'b0;
      r_b        <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_timeout  <= 1'b0;
      r_hold_err <= 1'b0;
      r_stop_req <= 1'b0;
      r_count    <= '0;
      r_n        <= '0;
      r_skew     <= '0;
      r_skew_cnt <= '0;
      r_to_cnt   <= '0;
    end else begin
      r_state    <= w_state_next;
      r_a        <= w_a_next;
      r_b        <= w_b_next;
      r_busy     <= (w_state_next != S_IDLE);
      r_done     <= w_done_next;
      r_timeout  <= w_timeout_next;
      r_hold_err <= w_hold_err_next;
      r_stop_req <= w_stop_req_next;
      r_count    <= w_count_next;
      r_n        <= w_n_next;
      r_skew     <= w_skew_next;
      r_skew_cnt <= w_skew_cnt_next;
      r_to_cnt   <= w_to_cnt_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_a_next        = r_a;
    w_b_next        = r_b;
    w_done_next     = 1'b0;
    w_timeout_next  = r_timeout;
    w_hold_err_next = r_hold_err;
    w_count_next    = r_count;
    w_n_next        = r_n;
    w_skew_next     = r_skew;
    w_skew_cnt_next = r_skew_cnt;
    w_to_cnt_next   = r_to_cnt;
    w_launch        = 1'b0;
    // Stop is remembered in every busy state and consumed at completion.
    w_stop_req_next = r_stop_req | (bus.stop && (r_state != S_IDLE));
    // The first handshake of a run uses the skew being sampled right now.
    w_launch_skew   = (r_state == S_IDLE) ? bus.skew : r_skew;
    w_count_inc     = (&r_count) ? r_count : r_count + CNT_W'(1);

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_n_next        = bus.n_cycles;
          w_skew_next     = bus.skew;
          w_count_next    = '0;
          w_timeout_next  = 1'b0;
          w_hold_err_next = 1'b0;
          w_stop_req_next = 1'b0;
          w_launch        = 1'b1;
        end
      end
      S_RISE_SKEW: begin
        if (w_c_sync) begin
          w_hold_err_next = 1'b1;
          w_a_next        = 1'b0;
          w_b_next        = 1'b0;
          w_state_next    = S_ERROR;
        end else if (r_skew_cnt == 4'd1) begin
          w_b_next      = 1'b1;
          w_to_cnt_next = '0;
          w_state_next  = S_WAIT_HI;
        end else begin
          w_skew_cnt_next = r_skew_cnt - 4'd1;
        end
      end
      S_WAIT_HI: begin
        if (w_c_sync) begin
          w_a_next = 1'b0;
          if (r_skew == 4'd0) begin
            w_b_next      = 1'b0;
            w_to_cnt_next = '0;
            w_state_next  = S_WAIT_LO;
          end else begin
            w_skew_cnt_next = r_skew;
            w_state_next    = S_FALL_SKEW;
          end
        end else if (r_to_cnt == TO_LAST) begin
          w_timeout_next = 1'b1;
          w_a_next       = 1'b0;
          w_b_next       = 1'b0;
          w_state_next   = S_ERROR;
        end else begin
          w_to_cnt_next = r_to_cnt + TO_W'(1);
        end
      end
      S_FALL_SKEW: begin
        if (!w_c_sync) begin
          w_hold_err_next = 1'b1;
          w_a_next        = 1'b0;
          w_b_next        = 1'b0;
          w_state_next    = S_ERROR;
        end else if (r_skew_cnt == 4'd1) begin
          w_b_next      = 1'b0;
          w_to_cnt_next = '0;
          w_state_next  = S_WAIT_LO;
        end else begin
          w_skew_cnt_next = r_skew_cnt - 4'd1;
        end
      end
      S_WAIT_LO: begin
        if (!w_c_sync) begin
          w_count_next = w_count_inc;
          if (((r_n != 8'd0) && (w_count_inc == CNT_W'(r_n))) ||
              r_stop_req || bus.stop) begin
            // Count limit and stop together still yield one DONE.
            w_done_next     = 1'b1;
            w_stop_req_next = 1'b0;
            w_state_next    = S_DONE;
          end else begin
            w_launch = 1'b1;
          end
        end else if (r_to_cnt == TO_LAST) begin
          w_timeout_next = 1'b1;
          w_state_next   = S_ERROR;
        end else begin
          w_to_cnt_next = r_to_cnt + TO_W'(1);
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      S_ERROR: begin
        w_a_next = 1'b0;
        w_b_next = 1'b0;
        if (bus.clr) w_state_next = S_IDLE;
      end
      default: begin
        w_a_next     = 1'b0;
        w_b_next     = 1'b0;
        w_state_next = S_IDLE;
      end
    endcase

    // Start of a handshake: a rises now; with zero skew b rises with it and
    // the rise window is skipped entirely.
    if (w_launch) begin
      w_a_next = 1'b1;
      if (w_launch_skew == 4'd0) begin
        w_b_next      = 1'b1;
        w_to_cnt_next = '0;
        w_state_next  = S_WAIT_HI;
      end else begin
        w_skew_cnt_next = w_launch_skew;
        w_state_next    = S_RISE_SKEW;
      end
    end
  end

  assign bus.a_out       = r_a;
  assign bus.b_out       = r_b;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.timeout     = r_timeout;
  assign bus.hold_err    = r_hold_err;
  assign bus.cycle_count = r_count;

endmodule
